// File: rtl/generador_trafico.sv
// Traffic generator/checker: fills CHANNELS input FIFOs with tagged bursts, drains and
// tag-checks the output FIFOs, counts words per output and reports a pass/fail verdict.
module generador_trafico #(
  parameter int WORD_SIZE = 10,
  parameter int CHANNELS  = 4,
  parameter int CH_BITS   = 2,
  parameter int CNT_W     = 5,
  parameter int LEN_W     = 4,
  parameter int QUIET_CYC = 8
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_start,
  input  logic                          i_rotate,
  input  logic [LEN_W-1:0]              i_burst_len,
  input  logic [CHANNELS-1:0]           i_fifo_almost_full,
  output logic [CHANNELS-1:0]           o_fifo_wr,
  output logic [CHANNELS*WORD_SIZE-1:0] o_fifo_data_in,
  input  logic [CHANNELS-1:0]           i_out_empty,
  output logic [CHANNELS-1:0]           o_out_rd,
  input  logic [CHANNELS*WORD_SIZE-1:0] i_out_data,
  input  logic                          i_req,
  input  logic [CH_BITS-1:0]            i_idx,
  output logic [CNT_W-1:0]              o_data_out_contador,
  output logic                          o_valid,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_pass,
  output logic [CNT_W-1:0]              o_err_count
);

  localparam int PAY_W = WORD_SIZE - CH_BITS;
  localparam int QW    = $clog2(QUIET_CYC + 1);
  localparam int SUM_W = CNT_W + CH_BITS + LEN_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                        r_state, w_state_nx;
  logic                          r_rotate;
  logic [LEN_W-1:0]              r_len;
  logic [LEN_W-1:0]              r_idx [CHANNELS];
  logic [CHANNELS-1:0]           r_wr;
  logic [CHANNELS*WORD_SIZE-1:0] r_data;
  logic [CHANNELS-1:0]           r_rd_q;
  logic [QW-1:0]                 r_quiet;
  logic [CNT_W-1:0]              r_cnt [CHANNELS];
  logic [CNT_W-1:0]              w_cnt_nx [CHANNELS];
  logic [CNT_W-1:0]              r_err, w_err_nx;
  logic [SUM_W-1:0]              w_sum_nx, w_expect;
  logic [CHANNELS-1:0]           w_wr_dec;
  logic [CHANNELS*WORD_SIZE-1:0] w_word;
  logic                          w_fill_done, w_start_ok, w_all_empty;
  logic                          r_busy, r_done, r_pass, r_valid;
  logic [CNT_W-1:0]              r_cnt_out;
  logic                          w_unused_data;

  assign w_start_ok    = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_all_empty   = &i_out_empty;
  assign w_expect      = SUM_W'(CHANNELS) * SUM_W'(r_len);
  assign w_unused_data = ^i_out_data;

  // Per-channel write decision and the tagged word for the current index
  always_comb begin
    w_wr_dec    = '0;
    w_word      = '0;
    w_fill_done = 1'b1;
    for (int c = 0; c < CHANNELS; c++) begin
      if (r_idx[c] < r_len) begin
        w_fill_done = 1'b0;
        w_wr_dec[c] = ~i_fifo_almost_full[c];
      end else begin
        w_wr_dec[c] = 1'b0;
      end
      if (r_rotate) begin
        w_word[c*WORD_SIZE +: WORD_SIZE] = {CH_BITS'(c) + CH_BITS'(r_idx[c]), PAY_W'(r_idx[c])};
      end else begin
        w_word[c*WORD_SIZE +: WORD_SIZE] = {CH_BITS'(c), PAY_W'(r_idx[c])};
      end
    end
  end

  // Next-state logic and output-FIFO read strobes
  always_comb begin
    w_state_nx = r_state;
    o_out_rd   = '0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nx = S_FILL;
        else         w_state_nx = S_IDLE;
      end
      S_FILL: begin
        o_out_rd = ~i_out_empty;
        if (w_fill_done) w_state_nx = S_DRAIN;
        else             w_state_nx = S_FILL;
      end
      S_DRAIN: begin
        o_out_rd = ~i_out_empty;
        if (w_all_empty && (r_quiet == QW'(QUIET_CYC - 1))) w_state_nx = S_DONE;
        else                                                w_state_nx = S_DRAIN;
      end
      S_DONE: begin
        if (i_start) w_state_nx = S_FILL;
        else         w_state_nx = S_DONE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Saturating per-output counters and tag-error count for data read last cycle
  always_comb begin
    w_err_nx = r_err;
    w_sum_nx = '0;
    for (int k = 0; k < CHANNELS; k++) w_cnt_nx[k] = r_cnt[k];
    if (w_start_ok) begin
      for (int k = 0; k < CHANNELS; k++) w_cnt_nx[k] = '0;
      w_err_nx = '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (r_rd_q[k]) begin
          if (r_cnt[k] != CNT_MAX) w_cnt_nx[k] = r_cnt[k] + CNT_W'(1);
          else                     w_cnt_nx[k] = r_cnt[k];
          if ((i_out_data[k*WORD_SIZE+PAY_W +: CH_BITS] != CH_BITS'(k)) && (w_err_nx != CNT_MAX))
            w_err_nx = w_err_nx + CNT_W'(1);
          else
            w_err_nx = w_err_nx;
        end else begin
          w_cnt_nx[k] = r_cnt[k];
        end
      end
    end
    for (int k = 0; k < CHANNELS; k++) w_sum_nx = w_sum_nx + SUM_W'(w_cnt_nx[k]);
  end

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nx;
  end

  // Fill sequencing: run parameters latched at start, one registered write per channel
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rotate <= 1'b0;
      r_len    <= '0;
      r_wr     <= '0;
      r_data   <= '0;
      for (int c = 0; c < CHANNELS; c++) r_idx[c] <= '0;
    end else if (w_start_ok) begin
      r_rotate <= i_rotate;
      r_len    <= i_burst_len;
      r_wr     <= '0;
      for (int c = 0; c < CHANNELS; c++) r_idx[c] <= '0;
    end else if (r_state == S_FILL) begin
      r_wr <= w_wr_dec;
      for (int c = 0; c < CHANNELS; c++) begin
        if (w_wr_dec[c]) begin
          r_idx[c]                         <= r_idx[c] + LEN_W'(1);
          r_data[c*WORD_SIZE +: WORD_SIZE] <= w_word[c*WORD_SIZE +: WORD_SIZE];
        end
      end
    end else begin
      r_wr <= '0;
    end
  end

  // Drain bookkeeping: pending reads, counters, errors and quiet-cycle count
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rd_q  <= '0;
      r_err   <= '0;
      r_quiet <= '0;
      for (int k = 0; k < CHANNELS; k++) r_cnt[k] <= '0;
    end else begin
      r_rd_q <= o_out_rd;
      r_err  <= w_err_nx;
      for (int k = 0; k < CHANNELS; k++) r_cnt[k] <= w_cnt_nx[k];
      if ((r_state == S_DRAIN) && w_all_empty) r_quiet <= r_quiet + QW'(1);
      else                                     r_quiet <= '0;
    end
  end

  // Status flags; pass is evaluated on the values the counters take this edge
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
    end else begin
      r_busy <= (w_state_nx == S_FILL) || (w_state_nx == S_DRAIN);
      r_done <= (w_state_nx == S_DONE);
      r_pass <= (w_state_nx == S_DONE) && (w_err_nx == '0) && (w_sum_nx == w_expect);
    end
  end

  // Counter readout: value as of the request edge, held between requests
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_valid   <= 1'b0;
      r_cnt_out <= '0;
    end else if (i_req) begin
      r_valid   <= 1'b1;
      r_cnt_out <= r_cnt[i_idx];
    end else begin
      r_valid   <= 1'b0;
    end
  end

  assign o_fifo_wr           = r_wr;
  assign o_fifo_data_in      = r_data;
  assign o_data_out_contador = r_cnt_out;
  assign o_valid             = r_valid;
  assign o_busy              = r_busy;
  assign o_done              = r_done;
  assign o_pass              = r_pass;
  assign o_err_count         = r_err;

endmodule

// File: tb/tb_generador_trafico.sv
// Bench for generador_trafico: ideal loopback interconnect routing words by tag, and an
// expected-traffic model computed from the burst rules.
module tb_generador_trafico;
  localparam int WS = 10;
  localparam int CH = 4;
  localparam int CB = 2;
  localparam int CW = 5;
  localparam int LW = 4;
  localparam int QC = 8;
  localparam int PW = WS - CB;

  logic              clk = 1'b0;
  logic              reset, start, rotate, req;
  logic [LW-1:0]     burst_len;
  logic [CH-1:0]     af, wr, out_rd;
  logic [CH-1:0]     out_empty = '1;
  logic [CH*WS-1:0]  din;
  logic [CH*WS-1:0]  out_data = '0;
  logic [CB-1:0]     idx;
  logic [CW-1:0]     cnt_out, err_count;
  logic              valid, busy, done, pass;

  int checks = 0;
  int errors = 0;
  int inj_req = 0;
  int inj_done = 0;
  logic [WS-1:0] outq   [CH][$];
  logic [WS-1:0] wr_log [CH][$];

  always #5 clk = ~clk;

  generador_trafico #(.WORD_SIZE(WS), .CHANNELS(CH), .CH_BITS(CB), .CNT_W(CW),
                      .LEN_W(LW), .QUIET_CYC(QC)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_rotate(rotate),
    .i_burst_len(burst_len), .i_fifo_almost_full(af), .o_fifo_wr(wr),
    .o_fifo_data_in(din), .i_out_empty(out_empty), .o_out_rd(out_rd),
    .i_out_data(out_data), .i_req(req), .i_idx(idx),
    .o_data_out_contador(cnt_out), .o_valid(valid), .o_busy(busy), .o_done(done),
    .o_pass(pass), .o_err_count(err_count)
  );

  // Ideal interconnect: each written word lands in the output FIFO named by its tag
  always @(posedge clk) begin
    logic [WS-1:0] w;
    logic [CH-1:0] emp;
    if (reset) begin
      for (int k = 0; k < CH; k++) begin
        outq[k].delete();
        wr_log[k].delete();
      end
      out_empty <= '1;
      out_data  <= '0;
    end else begin
      if (start) for (int k = 0; k < CH; k++) wr_log[k].delete();
      for (int k = 0; k < CH; k++) begin
        if (out_rd[k] && (outq[k].size() > 0)) begin
          w = outq[k].pop_front();
          if ((k == 1) && (inj_req != inj_done)) begin
            w[WS-1 -: CB] = 2'd2;
            inj_done++;
          end
          out_data[k*WS +: WS] <= w;
        end
      end
      for (int c = 0; c < CH; c++) begin
        if (wr[c]) begin
          w = din[c*WS +: WS];
          wr_log[c].push_back(w);
          outq[int'(w[WS-1 -: CB])].push_back(w);
        end
      end
      for (int k = 0; k < CH; k++) emp[k] = (outq[k].size() == 0);
      out_empty <= emp;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete run followed by verdict, traffic and counter-readout checks
  task automatic run_check(input logic rot, input int len, input bit rand_af,
                           input bit hold, input bit inj, output int lat);
    int cyc;
    int d;
    int exp_cnt [CH];
    logic [WS-1:0] ew;
    if (inj) inj_req++;
    @(negedge clk);
    rotate = rot; burst_len = LW'(len); start = 1'b1;
    af = hold ? 4'b0100 : 4'b0000;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    chk("busy_after_start", busy, 1);
    if (hold) begin
      for (int h = 0; h < 10; h++) begin
        chk("wr2_held_low", wr[2], 0);
        @(negedge clk);
        cyc++;
      end
      chk("ch0_done_during_hold", wr_log[0].size(), len);
      af = '0;
    end
    while (!done && (cyc < 2000)) begin
      if (rand_af) af = CH'($urandom);
      @(negedge clk);
      cyc++;
    end
    af = '0;
    lat = cyc;
    chk("done_reached", done, 1);
    @(negedge clk);
    chk("done_stays", done, 1);
    chk("busy_in_done", busy, 0);
    chk("rd_idle_in_done", out_rd, 0);
    for (int k = 0; k < CH; k++) exp_cnt[k] = 0;
    for (int c = 0; c < CH; c++) begin
      chk("words_written", wr_log[c].size(), len);
      for (int i = 0; i < len; i++) begin
        d = rot ? (c + i) % CH : c;
        exp_cnt[d]++;
        ew = {CB'(d), PW'(i)};
        if (i < wr_log[c].size()) chk("word_value", wr_log[c][i], ew);
      end
    end
    chk("err_count", err_count, inj ? 1 : 0);
    chk("pass", pass, inj ? 0 : 1);
    for (int k = 0; k < CH; k++) begin
      req = 1'b1; idx = CB'(k);
      @(negedge clk);
      chk("rd_valid", valid, 1);
      chk("rd_counter", cnt_out, exp_cnt[k]);
    end
    req = 1'b0;
    @(negedge clk);
    chk("valid_drops", valid, 0);
    chk("counter_holds", cnt_out, exp_cnt[CH-1]);
  endtask

  initial begin
    int lat, nw, cyc;
    logic [WS-1:0] ex_ch0 [4];
    reset = 1'b1; start = 1'b0; rotate = 1'b0; burst_len = '0;
    af = '0; req = 1'b0; idx = '0;
    repeat (3) @(negedge clk);
    chk("rst_wr", wr, 0);
    chk("rst_data_zero", (din == '0), 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_valid", valid, 0);
    chk("rst_cnt_out", cnt_out, 0);
    chk("rst_out_rd", out_rd, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // Reset asserted on the third write of a burst_len=6 run
    rotate = 1'b0; burst_len = 4'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nw = 0; cyc = 0;
    while ((nw < 3) && (cyc < 100)) begin
      if (wr[0]) nw++;
      if (nw < 3) begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("third_write_seen", nw, 3);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_wr", wr, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("postrst_wr", wr, 0);
    chk("postrst_busy", busy, 0);
    for (int k = 0; k < CH; k++) begin
      req = 1'b1; idx = CB'(k);
      @(negedge clk);
      chk("postrst_counter", cnt_out, 0);
    end
    req = 1'b0;

    run_check(1'b0, 6, 1'b0, 1'b0, 1'b0, lat);
    run_check(1'b1, 4, 1'b0, 1'b0, 1'b0, lat);
    ex_ch0 = '{10'h000, 10'h101, 10'h202, 10'h303};
    for (int i = 0; i < 4; i++)
      if (i < wr_log[0].size()) chk("rot_ch0_word", wr_log[0][i], ex_ch0[i]);
    run_check(1'b0, 6, 1'b0, 1'b1, 1'b0, lat);
    run_check(1'b0, 6, 1'b0, 1'b0, 1'b1, lat);
    run_check(1'b0, 0, 1'b0, 1'b0, 1'b0, lat);
    chk("len0_latency", (lat <= QC + 2), 1);
    for (int r = 0; r < 4; r++)
      run_check(1'($urandom_range(0, 1)), int'($urandom_range(1, 15)), 1'b1, 1'b0, 1'b0, lat);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
